// File: rtl/axil_write_slave.sv
// axil_write_slave: AXI4-Lite write-only slave into a bank of 32-bit registers, with a local combinational read port
module axil_write_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  WR_PULSE,
  output logic [7:0]            WR_INDEX,
  input  logic [7:0]            LOC_RADDR,
  output logic [31:0]           LOC_RDATA
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(4 * NUM_REGS);
  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
  state_t                state;
  logic                  aw_held, w_held, aw_hs, w_hs, in_range;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [3:0]            w_strb;
  logic [IW-1:0]         idx;
  logic [31:0]           regs [NUM_REGS];
  assign AWREADY   = !ARESET && state == IDLE && !aw_held;
  assign WREADY    = !ARESET && state == IDLE && !w_held;
  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign in_range  = aw_addr < LIMIT;
  assign idx       = aw_addr[IW+1:2];
  assign LOC_RDATA = 32'(LOC_RADDR) < NUM_REGS ? regs[LOC_RADDR[IW-1:0]] : '0;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      BVALID   <= 1'b0;
      BRESP    <= 2'b00;
      WR_PULSE <= 1'b0;
      WR_INDEX <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      WR_PULSE <= 1'b0;
      WR_INDEX <= '0;
      case (state)
        IDLE: begin
          if (aw_hs) aw_addr <= AWADDR;
          if (w_hs) begin
            w_data <= WDATA;
            w_strb <= WSTRB;
          end
          // both halves present (held or arriving now) launch the write and free the holding flags
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            state   <= WRITE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end else begin
            aw_held <= aw_held || aw_hs;
            w_held  <= w_held || w_hs;
          end
        end
        WRITE: begin
          if (in_range)
            for (int b = 0; b < 4; b++)
              if (w_strb[b]) regs[idx][8*b +: 8] <= w_data[8*b +: 8];
          WR_PULSE <= in_range;
          WR_INDEX <= in_range ? 8'(idx) : 8'd0;
          BRESP    <= in_range ? 2'b00 : 2'b10;
          BVALID   <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_write_slave.sv
// tb_axil_write_slave: directed checks of the AXI4-Lite write slave with hand-computed expectations
module tb_axil_write_slave;
  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic [31:0] AWADDR = '0, WDATA = '0, LOC_RDATA;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b1;
  logic        AWREADY, WREADY, BVALID, WR_PULSE;
  logic [3:0]  WSTRB = '0;
  logic [1:0]  BRESP;
  logic [7:0]  WR_INDEX, LOC_RADDR = '0;
  int          checks = 0, failures = 0;
  axil_write_slave dut (
    .ACLK(ACLK), .ARESET(ARESET), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .WR_PULSE(WR_PULSE), .WR_INDEX(WR_INDEX), .LOC_RADDR(LOC_RADDR), .LOC_RDATA(LOC_RDATA)
  );
  always #5 ACLK = ~ACLK;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  task automatic rd(input logic [7:0] i, input logic [31:0] exp);
    LOC_RADDR = i;
    #1;
    chk($sformatf("loc_rdata[%0d]", i), LOC_RDATA, exp);
  endtask
  // lead>0: W leads AW by lead cycles; lead<0: AW leads W; hold: cycles BREADY stays low after BVALID
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int hold, input logic [1:0] exp_resp,
                           input logic [7:0] exp_idx);
    int   k = 0;
    int   lag = lead < 0 ? -lead : lead;
    logic aw_f, w_f, aw_done = 1'b0, w_done = 1'b0;
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = lead <= 0; WVALID = lead >= 0;
    BREADY = hold == 0;
    while (!(aw_done && w_done) && k < 20) begin
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      tick();
      k++;
      if (aw_f) begin AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_f) begin WVALID = 1'b0; w_done = 1'b1; end
      if (k == 1 && lead != 0) begin
        chk("other_still_ready", lead > 0 ? AWREADY : WREADY, 1);
        chk("held_not_ready", lead > 0 ? WREADY : AWREADY, 0);
      end
      if (k == lag && lead != 0) begin
        if (lead > 0) AWVALID = 1'b1;
        else WVALID = 1'b1;
      end
    end
    if (!(aw_done && w_done)) begin
      chk("handshake_timeout", 0, 1);
      AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
      return;
    end
    chk("write_no_bvalid", BVALID, 0);
    chk("write_awready", AWREADY, 0);
    tick();
    chk("bvalid", BVALID, 1);
    chk("bresp", BRESP, exp_resp);
    chk("wr_pulse", WR_PULSE, exp_resp == 2'b00);
    chk("wr_index", WR_INDEX, exp_idx);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("stall_bvalid", BVALID, 1);
      chk("stall_bresp", BRESP, exp_resp);
      chk("stall_ready", {AWREADY, WREADY}, 2'b00);
      chk("stall_pulse", WR_PULSE, 0);
    end
    BREADY = 1'b1;
    tick();
    chk("done_bvalid", BVALID, 0);
    chk("done_ready", {AWREADY, WREADY}, 2'b11);
    chk("done_pulse", {WR_PULSE, WR_INDEX}, 0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ready", {AWREADY, WREADY}, 2'b00);
    chk("rst_outputs", {BVALID, BRESP, WR_PULSE, WR_INDEX}, 0);
    ARESET = 1'b0;
    #1;
    chk("post_rst_ready", {AWREADY, WREADY}, 2'b11);
    rd(0, 0);
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 8'd2);
    rd(2, 32'hDEADBEEF);
    axi_write(32'h04, 32'hAABBCCDD, 4'hF, -2, 0, 2'b00, 8'd1);
    rd(1, 32'hAABBCCDD);
    axi_write(32'h04, 32'h11223344, 4'b0101, 3, 0, 2'b00, 8'd1);
    rd(1, 32'hAA22CC44);
    axi_write(32'h07, 32'h99999999, 4'h0, 0, 0, 2'b00, 8'd1);
    rd(1, 32'hAA22CC44);
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10, 8'd0);
    axi_write(32'h80000008, 32'h12345678, 4'hF, 1, 0, 2'b10, 8'd0);
    for (int i = 0; i < 16; i++)
      rd(8'(i), i == 1 ? 32'hAA22CC44 : i == 2 ? 32'hDEADBEEF : 32'h0);
    axi_write(32'h14, 32'h00000055, 4'hF, 0, 5, 2'b00, 8'd5);
    rd(5, 32'h55);
    rd(16, 0);
    rd(255, 0);
    AWADDR = 32'h0C; WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    chk("pre_abort_bvalid", BVALID, 1);
    ARESET = 1'b1;
    tick();
    chk("abort_bvalid", BVALID, 0);
    chk("abort_ready_in_rst", {AWREADY, WREADY}, 2'b00);
    ARESET = 1'b0; BREADY = 1'b1;
    #1;
    chk("abort_ready_after", {AWREADY, WREADY}, 2'b11);
    rd(3, 0);
    rd(2, 0);
    for (int i = 0; i < 10; i++)
      axi_write(32'(4 * i), 32'(i), 4'hF, 0, 0, 2'b00, 8'(i));
    for (int i = 0; i < 11; i++)
      rd(8'(i), i < 10 ? 32'(i) : 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
